// File: rtl/serialize_word_to_bit_stream.sv
// Parallel-to-serial stage: valid/ready WIDTH-bit words in, MSB-first bit stream out.
// Define SERIALIZE_PREFETCH_EN to add a one-word holding register for gapless streaming.
module serialize_word_to_bit_stream #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             new_bit,
  output logic             bit_valid,
  output logic             last
);
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] sh, sh_d;
  logic             bit_d, vld_d, last_d;
  logic             xfer;

  assign xfer = up_valid && up_ready;

`ifdef SERIALIZE_PREFETCH_EN
  logic [WIDTH-1:0] hold, hold_d;
  logic             hold_full, hold_full_d;

  assign up_ready = !hold_full;
`else
  assign up_ready = (state == IDLE);
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sh_d    = sh;
`ifdef SERIALIZE_PREFETCH_EN
    hold_d      = hold;
    hold_full_d = hold_full;
`endif
    case (state)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          cnt_d   = CNT_INIT;
          sh_d    = up_data;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          sh_d  = {sh[WIDTH-2:0], 1'b0};
          cnt_d = cnt - CW'(1);
`ifdef SERIALIZE_PREFETCH_EN
          if (xfer) begin
            hold_d      = up_data;
            hold_full_d = 1'b1;
          end
`endif
        end else begin
`ifdef SERIALIZE_PREFETCH_EN
          // Buffered word takes over the shifter on the last-bit edge; a word
          // offered exactly on that edge (buffer empty) goes straight in too.
          if (hold_full) begin
            cnt_d       = CNT_INIT;
            sh_d        = hold;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            cnt_d = CNT_INIT;
            sh_d  = up_data;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered copies of the next-state view of the shifter.
    vld_d  = (state_d == SHIFT);
    bit_d  = vld_d ? sh_d[WIDTH-1] : IDLE_BIT;
    last_d = vld_d && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      new_bit   <= IDLE_BIT;
      bit_valid <= 1'b0;
      last      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sh        <= sh_d;
      new_bit   <= bit_d;
      bit_valid <= vld_d;
      last      <= last_d;
    end
  end

`ifdef SERIALIZE_PREFETCH_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      hold      <= hold_d;
      hold_full <= hold_full_d;
    end
  end
`endif

endmodule

// File: doc/serialize_word_to_bit_stream.md
# serialize_word_to_bit_stream

Parallel-to-serial stage that sits directly upstream of the shift-register sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on new_bit, with a qualifying bit_valid strobe and a last-bit marker. Outside a word it drives a constant filler bit, so the detector downstream sees a defined stream on every cycle.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- IDLE_BIT, 1'b0: value driven on new_bit whenever bit_valid is 0.
- clk  input  1  single clock; all flops on posedge.
- rst  input  1  asynchronous, active-low reset; asserting it clears state immediately, release is synchronous to clk.
- up_valid  input  1  upstream word available.
- up_data  input  WIDTH  word to serialize; must stay stable while up_valid && !up_ready.
- up_ready  output  1  block can accept a word this cycle; combinational from internal state only, never from up_valid.
- new_bit  output  1  serial bit, registered; feeds the detector's new_bit input.
- bit_valid  output  1  new_bit carries word data this cycle, registered.
- last  output  1  current bit is bit 0 (the final bit) of the word, registered.

## Operation
- Handshake: a word transfers on a posedge where up_valid && up_ready. up_valid may rise at any time. Once raised, up_valid must not drop before the transfer completes.
- FSM states:
  - IDLE: shifter empty; bit_valid=0, new_bit=IDLE_BIT.
  - SHIFT: shifter holds the word; a down-counter (width $clog2(WIDTH)) tracks the remaining bits.
- IDLE -> SHIFT on transfer. The shifter loads up_data and the counter loads WIDTH-1.
- In SHIFT, each edge advances the shifter by one bit, MSB first, and decrements the counter. last=1 while the counter is 0.
- SHIFT -> IDLE on the edge that retires the last bit, unless a next word is available (see Configuration).
- Bit order: up_data[WIDTH-1] first, up_data[0] last. last and bit_valid are both 1 on the up_data[0] cycle.
- The counter never wraps. Leaving SHIFT at count 0 is the only exit.
- Reset mid-word: the word in flight and any buffered word are discarded. bit_valid and last drop to 0 and new_bit goes to IDLE_BIT asynchronously. The state goes to IDLE.

## Timing
- Reset values:
  - new_bit=IDLE_BIT, bit_valid=0, last=0.
  - up_ready=1 (IDLE, buffer empty).
- Latency: a word transferred on edge k drives its MSB in the cycle after edge k and its LSB in the cycle after edge k+WIDTH-1.
- bit_valid is high for exactly WIDTH consecutive cycles per word.
- Without the prefetch buffer:
  - up_ready=1 only in IDLE.
  - Throughput is one word per WIDTH+1 cycles, with exactly one bit_valid=0 cycle between back-to-back words.
- With the prefetch buffer:
  - Throughput is one word per WIDTH cycles with no gap.
- A back-to-back gap cycle carries IDLE_BIT on new_bit.

## Configuration
- SERIALIZE_PREFETCH_EN defined: a one-entry holding register is compiled in, and up_ready = !buffer_full.
  - A word transferred in IDLE with the buffer empty goes straight to the shifter.
  - A word transferred while in SHIFT goes to the buffer.
  - On the last-bit edge, a full buffer loads the shifter and the state stays in SHIFT.
  - Back-to-back words produce a continuous bit_valid.
  - A transfer cannot coincide with buffer drain, because up_ready is 0 while the buffer is full.
- SERIALIZE_PREFETCH_EN undefined: no buffer and the one-cycle gap described under Timing; up_ready=0 throughout SHIFT.

## Test plan
- Single word, WIDTH=8, 8'hCC transferred on edge k -> new_bit 1,1,0,0,1,1,0,0 in cycles k+1..k+8, bit_valid=1 on those cycles, last=1 only in cycle k+8, then IDLE_BIT=0 with bit_valid=0.
- Chain into detect_6_bit_sequence_using_shift_reg, words 8'hCC then 8'h00 -> detected pulses after the sixth bit ("110011") of the first word, and nowhere else.
- Back-to-back, up_valid held high with 8'hA5 then 8'h5A:
  - macro undefined: bits 10100101, one gap cycle with bit_valid=0, then 01011010.
  - macro defined: 16 contiguous bit_valid cycles, and up_ready=0 only while the buffer holds 8'h5A.
- Backpressure: up_valid=1 with 8'h3C during SHIFT (macro undefined) -> up_ready=0 until IDLE, and 8'h3C is serialized intact after that.
- Reset asserted asynchronously mid-word, after the third bit of 8'hFF -> bit_valid=0 and new_bit=IDLE_BIT before the next edge, up_ready=1 after release, and no remaining bits are emitted.
- IDLE_BIT=1, WIDTH=4, word 4'b0000 -> idle cycles show new_bit=1, and exactly 4 zero bits appear with bit_valid=1.
